fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter IMEM_WORDS, default 32, number of 32-bit words in the instruction memory and the legal fetch range.
REQ-002 Parameter CNT_W, default 16, width of the fetch counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 freeze  input  1  hazard stall from the decode/hazard unit; hold fetch when high.
REQ-006 branch_taken  input  1  redirect request from execute stage.
REQ-007 branch_addr  input  32  redirect byte address; bits [1:0] ignored.
REQ-008 mem_addr  output  32  byte address to instruction memory; combinational copy of pc.
REQ-009 mem_instr  input  32  instruction word returned combinationally by the memory for mem_addr.
REQ-010 if_pc  output  32  registered PC+4 of the instruction in if_instr.
REQ-011 if_instr  output  32  registered fetched instruction.
REQ-012 if_valid  output  1  if_instr/if_pc hold a real instruction (0 = bubble).
REQ-013 state  output  2  current FSM state: RUN=0, STALL=1, REDIRECT=2, HALT=3.
REQ-014 fetch_count  output  CNT_W  number of instructions delivered, saturating.

Function
REQ-015 Internal pc register (32 bits, word-aligned, bits [1:0] always 0) drives mem_addr with zero latency.
REQ-016 Event priority each cycle: branch_taken > freeze > bounds check > normal fetch.
REQ-017 Normal fetch (RUN, freeze=0, branch_taken=0, pc in range): if_instr<=mem_instr, if_pc<=pc+4, if_valid<=1, pc<=pc+4, fetch_count+=1, next state RUN.
REQ-018 Freeze (branch_taken=0, freeze=1): pc, if_instr, if_pc, if_valid and fetch_count hold; next state STALL; STALL returns to RUN on the first cycle freeze=0 and performs a normal fetch in that cycle.
REQ-019 Redirect (branch_taken=1, any state, freeze ignored): pc<={branch_addr[31:2],2'b00}, if_valid<=0, if_instr<=0, if_pc<=0, fetch_count holds; next state REDIRECT.
REQ-020 REDIRECT lasts exactly one cycle, then behaves as RUN (fetch from the new pc if freeze=0, STALL if freeze=1); a further branch_taken in REDIRECT re-redirects.
REQ-021 Fetch latency: instruction at pc appears on if_instr one clock edge after pc is presented; branch penalty is exactly one bubble cycle.
REQ-022 pc wraps modulo 2^32 on increment; no overflow flag.
REQ-023 fetch_count saturates at 2^CNT_W-1 and does not wrap.
REQ-024 HALT: if_valid<=0, pc holds, fetch_count holds; left only by branch_taken (to REDIRECT) or rst.

Reset
REQ-025 rst high asynchronously forces pc=0, if_pc=0, if_instr=0, if_valid=0, state=RUN, fetch_count=0, including mid-stall or mid-redirect.
REQ-026 First fetch after rst deasserts occurs at the first rising edge with rst low, from address 0.

Configuration
REQ-027 Macro FETCH_BOUNDS_CHECK_EN: when defined, a fetch attempted with pc >= IMEM_WORDS*4 (no branch, no freeze) performs no fetch, sets if_valid<=0 and enters HALT.
REQ-028 Without FETCH_BOUNDS_CHECK_EN no range check exists, HALT is unreachable, and out-of-range addresses are fetched as normal.

Verification
REQ-029 Reset, then 4 free-running cycles with memory word n = n -> if_instr 0,1,2,3; if_pc 4,8,12,16; fetch_count 4; mem_addr 16.
REQ-030 freeze high 3 cycles after fetching pc=8 -> if_* and pc frozen, state=STALL for 3 cycles, next fetch delivers word at 12 with if_pc=16.
REQ-031 branch_taken=1, branch_addr=0x43 together with freeze=1 -> next cycle pc=0x40, if_valid=0, state=REDIRECT; following cycle if_instr=word 16, if_pc=0x44.
REQ-032 fetch_count preset near max (CNT_W=4, 20 fetches) -> fetch_count reads 15 and stays 15.
REQ-033 With FETCH_BOUNDS_CHECK_EN, IMEM_WORDS=4, free-run -> 4 valid fetches then state=HALT, if_valid=0; branch to 0 -> REDIRECT then fetch resumes; without macro -> 5th fetch valid at pc=16.
REQ-034 rst asserted asynchronously between clock edges during STALL -> all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch stage: PC sequencing, stall/redirect FSM and a registered IF/ID pipeline latch.
// Optional: define FETCH_BOUNDS_CHECK_EN to halt on fetches beyond IMEM_WORDS*4.
module fetch_controller #(
    parameter int unsigned IMEM_WORDS = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_instr,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic             if_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_e;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      if_pc_q;
    logic [31:0]      if_instr_q;
    logic             if_valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      pc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             oob_d;

    assign pc_d  = pc_q + 32'd4;
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign oob_d = BOUNDS_EN && (pc_q >= IMEM_BYTES);

    // REDIRECT and STALL both resolve like RUN; only HALT is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else if (branch_taken) begin
            pc_q       <= branch_addr & ~32'd3;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
            state_q    <= REDIRECT;
        end else begin
            case (state_q)
                HALT: begin
                    if_valid_q <= 1'b0;
                end
                default: begin
                    if (freeze) begin
                        state_q <= STALL;
                    end else if (oob_d) begin
                        if_valid_q <= 1'b0;
                        state_q    <= HALT;
                    end else begin
                        if_instr_q <= mem_instr;
                        if_pc_q    <= pc_d;
                        if_valid_q <= 1'b1;
                        pc_q       <= pc_d;
                        cnt_q      <= cnt_d;
                        state_q    <= RUN;
                    end
                end
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign if_valid    = if_valid_q;
    assign state       = state_q;
    assign fetch_count = cnt_q;

endmodule
